// File: rtl/lock_sequencer.sv
// ============================================================================
// lock_sequencer
//
// Control sequencer sitting between the keypad scanner and the door
// indicator/actuator outputs. Complete 8-bit keypad entries arrive through a
// valid/ready handshake and are compared against the stored passcode. A match
// opens the door for a timed window; mismatches are counted, and too many
// consecutive mismatches lock the keypad out for a timed period.
//
// Optional feature macro:
//   LOCK_PROG_EN  - when defined, the passcode can be rewritten while the door
//                   is open (prog_valid/prog_code, acknowledged by prog_ack).
//                   When undefined the passcode is the constant CODE and
//                   prog_ack is tied low.
//
// Parameters:
//   CODE            passcode loaded at reset
//   MAX_FAIL        consecutive failures that trigger lockout (>=1)
//   OPEN_CYCLES     cycles the door stays unlocked (>=1)
//   LOCKOUT_CYCLES  cycles the keypad stays locked out (>=1)
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-low reset
//   key_valid   key_code holds a complete entry
//   key_code    entered code
//   key_ready   sequencer can accept an entry (high only in IDLE)
//   relock      force early relock while open
//   prog_valid  passcode write request
//   prog_code   new passcode
//   prog_ack    one-cycle pulse: passcode written
//   locked      door locked
//   unlocked    door unlocked
//   error       wrong code, or lockout active
//   lockout     keypad locked out
//   fail_cnt    consecutive failures, saturating at MAX_FAIL
// ============================================================================
module lock_sequencer #(
    parameter logic [7:0] CODE           = 8'hD9,
    parameter int         MAX_FAIL       = 3,
    parameter int         OPEN_CYCLES    = 16,
    parameter int         LOCKOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    input  logic       relock,
    input  logic       prog_valid,
    input  logic [7:0] prog_code,
    output logic       prog_ack,
    output logic       locked,
    output logic       unlocked,
    output logic       error,
    output logic       lockout,
    output logic [1:0] fail_cnt
);

    localparam int MAX_CYCLES = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    // Timers are loaded with N-1 and leave their state on the cycle they read
    // zero, so each timed state lasts exactly N cycles.
    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]         FAIL_MAX  = 2'(MAX_FAIL);
    localparam logic [1:0]         FAIL_LAST = 2'(MAX_FAIL - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        OPEN,
        FAIL,
        LOCKOUT
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           key_q, key_d;
    logic [1:0]           fail_cnt_q, fail_cnt_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           passcode;

`ifdef LOCK_PROG_EN
    logic [7:0] passcode_q, passcode_d;
    logic       prog_ack_q, prog_ack_d;

    // Passcode writes are only honoured while the door is open; the new value
    // is used from the next CHECK onward.
    always_comb begin
        passcode_d = passcode_q;
        prog_ack_d = 1'b0;
        if (state_q == OPEN && prog_valid) begin
            passcode_d = prog_code;
            prog_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            passcode_q <= CODE;
            prog_ack_q <= 1'b0;
        end else begin
            passcode_q <= passcode_d;
            prog_ack_q <= prog_ack_d;
        end
    end

    assign passcode = passcode_q;
    assign prog_ack = prog_ack_q;
`else
    logic unused_prog;
    assign unused_prog = &{1'b0, prog_valid, prog_code};
    assign passcode    = CODE;
    assign prog_ack    = 1'b0;
`endif

    // Next-state logic. key_valid is only looked at in IDLE, so entries
    // offered in any other state are dropped rather than queued.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = key_code;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (key_q == passcode) begin
                    state_d    = OPEN;
                    fail_cnt_d = 2'd0;
                    timer_d    = OPEN_LOAD;
                end else if (fail_cnt_q == FAIL_LAST) begin
                    state_d    = LOCKOUT;
                    fail_cnt_d = FAIL_MAX;
                    timer_d    = LOCK_LOAD;
                end else begin
                    state_d    = FAIL;
                    fail_cnt_d = fail_cnt_q + 2'd1;
                end
            end
            OPEN: begin
                // An early relock leaves a nonzero count behind, so clear it
                // to keep the timer at zero outside the timed states.
                if (timer_q == '0 || relock) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            FAIL: begin
                state_d = IDLE;
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = IDLE;
                    fail_cnt_d = 2'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            key_q      <= 8'h00;
            fail_cnt_q <= 2'd0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign unlocked  = (state_q == OPEN);
    assign locked    = !unlocked;
    assign error     = (state_q == FAIL) || (state_q == LOCKOUT);
    assign lockout   = (state_q == LOCKOUT);
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// ============================================================================
// tb_lock_sequencer
//
// Directed testbench for lock_sequencer with default parameters
// (CODE=8'hD9, MAX_FAIL=3, OPEN_CYCLES=16, LOCKOUT_CYCLES=64).
// Indicator outputs are compared as one packed vector:
//   {locked, unlocked, error, lockout, key_ready, fail_cnt[1:0]}
// Inputs change and outputs are sampled 1ns after each rising edge.
// ============================================================================
module tb_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic       relock;
    logic       prog_valid;
    logic [7:0] prog_code;
    logic       prog_ack;
    logic       locked;
    logic       unlocked;
    logic       error;
    logic       lockout;
    logic [1:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    logic [6:0] obs;
    assign obs = {locked, unlocked, error, lockout, key_ready, fail_cnt};

    // Expected indicator vectors, named by state and fail count.
    localparam logic [6:0] IDLE0   = 7'b1000100;
    localparam logic [6:0] IDLE1   = 7'b1000101;
    localparam logic [6:0] IDLE2   = 7'b1000110;
    localparam logic [6:0] CHECK0  = 7'b1000000;
    localparam logic [6:0] CHECK2  = 7'b1000010;
    localparam logic [6:0] OPEN0   = 7'b0100000;
    localparam logic [6:0] FAIL1   = 7'b1010001;
    localparam logic [6:0] FAIL2   = 7'b1010010;
    localparam logic [6:0] LOCKED3 = 7'b1011011;

    lock_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .relock     (relock),
        .prog_valid (prog_valid),
        .prog_code  (prog_code),
        .prog_ack   (prog_ack),
        .locked     (locked),
        .unlocked   (unlocked),
        .error      (error),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry for a single edge; afterwards the DUT is in CHECK.
    task automatic enter_code(input logic [7:0] c);
        key_code  = c;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b want %b", obs, IDLE0);
        end
        checks++;
        if (prog_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_prog_ack: got %b want 0", prog_ack);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL reset_idle_hold: got %b want %b", obs, IDLE0);
        end
    endtask

    task automatic test_unlock();
        do_reset();
        enter_code(8'hD9);
        checks++;
        if (obs !== CHECK0) begin
            errors++;
            $display("[TB] FAIL unlock_check_cycle: got %b want %b", obs, CHECK0);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs !== OPEN0) begin
                errors++;
                $display("[TB] FAIL unlock_open cycle %0d: got %b want %b", i, obs, OPEN0);
            end
            tick();
        end
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL unlock_relocked: got %b want %b", obs, IDLE0);
        end
    endtask

    task automatic test_lockout();
        do_reset();
        enter_code(8'h00);
        tick();
        checks++;
        if (obs !== FAIL1) begin
            errors++;
            $display("[TB] FAIL lockout_fail1: got %b want %b", obs, FAIL1);
        end
        tick();
        checks++;
        if (obs !== IDLE1) begin
            errors++;
            $display("[TB] FAIL lockout_idle1: got %b want %b", obs, IDLE1);
        end
        enter_code(8'h00);
        tick();
        checks++;
        if (obs !== FAIL2) begin
            errors++;
            $display("[TB] FAIL lockout_fail2: got %b want %b", obs, FAIL2);
        end
        tick();
        enter_code(8'h00);
        checks++;
        if (obs !== CHECK2) begin
            errors++;
            $display("[TB] FAIL lockout_check2: got %b want %b", obs, CHECK2);
        end
        tick();
        // key_valid offered mid-lockout must be dropped.
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                key_code  = 8'hD9;
                key_valid = 1'b1;
            end
            if (i == 13) key_valid = 1'b0;
            checks++;
            if (obs !== LOCKED3) begin
                errors++;
                $display("[TB] FAIL lockout_active cycle %0d: got %b want %b", i, obs, LOCKED3);
            end
            tick();
        end
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL lockout_release: got %b want %b", obs, IDLE0);
        end
        enter_code(8'hD9);
        tick();
        checks++;
        if (obs !== OPEN0) begin
            errors++;
            $display("[TB] FAIL lockout_then_unlock: got %b want %b", obs, OPEN0);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
    endtask

    task automatic test_fail_recovery();
        do_reset();
        enter_code(8'h00);
        tick();
        tick();
        enter_code(8'h11);
        tick();
        tick();
        checks++;
        if (obs !== IDLE2) begin
            errors++;
            $display("[TB] FAIL recovery_two_fails: got %b want %b", obs, IDLE2);
        end
        enter_code(8'hD9);
        tick();
        checks++;
        if (obs !== OPEN0) begin
            errors++;
            $display("[TB] FAIL recovery_unlock: got %b want %b", obs, OPEN0);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        enter_code(8'h00);
        tick();
        checks++;
        if (obs !== FAIL1) begin
            errors++;
            $display("[TB] FAIL recovery_single_fail: got %b want %b", obs, FAIL1);
        end
        tick();
        checks++;
        if (obs !== IDLE1) begin
            errors++;
            $display("[TB] FAIL recovery_idle1: got %b want %b", obs, IDLE1);
        end
    endtask

    task automatic test_relock();
        do_reset();
        enter_code(8'hD9);
        tick();
        // Offer a wrong entry throughout OPEN; accepting it would show FAIL.
        key_code  = 8'h00;
        key_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (obs !== OPEN0) begin
                errors++;
                $display("[TB] FAIL relock_open cycle %0d: got %b want %b", c, obs, OPEN0);
            end
            tick();
        end
        relock = 1'b1;
        tick();
        relock    = 1'b0;
        key_valid = 1'b0;
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL relock_early: got %b want %b", obs, IDLE0);
        end
        tick();
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL relock_no_queued_entry: got %b want %b", obs, IDLE0);
        end
        // Relock on the final OPEN cycle coincides with timer expiry.
        enter_code(8'hD9);
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (obs !== OPEN0) begin
            errors++;
            $display("[TB] FAIL relock_last_open: got %b want %b", obs, OPEN0);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL relock_at_expiry: got %b want %b", obs, IDLE0);
        end
    endtask

`ifdef LOCK_PROG_EN
    task automatic test_prog();
        do_reset();
        enter_code(8'hD9);
        tick();
        prog_code  = 8'h3C;
        prog_valid = 1'b1;
        relock     = 1'b1;
        checks++;
        if (prog_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_ack_early: got %b want 0", prog_ack);
        end
        tick();
        prog_valid = 1'b0;
        relock     = 1'b0;
        checks++;
        if (prog_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prog_ack_pulse: got %b want 1", prog_ack);
        end
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL prog_with_relock: got %b want %b", obs, IDLE0);
        end
        tick();
        checks++;
        if (prog_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_ack_width: got %b want 0", prog_ack);
        end
        enter_code(8'hD9);
        tick();
        checks++;
        if (obs !== FAIL1) begin
            errors++;
            $display("[TB] FAIL prog_old_code_rejected: got %b want %b", obs, FAIL1);
        end
        tick();
        // A write request outside OPEN must be ignored.
        prog_code  = 8'h55;
        prog_valid = 1'b1;
        tick();
        prog_valid = 1'b0;
        checks++;
        if (prog_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_idle_ignored: got %b want 0", prog_ack);
        end
        enter_code(8'h3C);
        tick();
        checks++;
        if (obs !== OPEN0) begin
            errors++;
            $display("[TB] FAIL prog_new_code_opens: got %b want %b", obs, OPEN0);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        do_reset();
        enter_code(8'hD9);
        tick();
        checks++;
        if (obs !== OPEN0) begin
            errors++;
            $display("[TB] FAIL prog_reset_restores: got %b want %b", obs, OPEN0);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
    endtask
`else
    task automatic test_prog();
        do_reset();
        enter_code(8'hD9);
        tick();
        prog_code  = 8'h3C;
        prog_valid = 1'b1;
        tick();
        prog_valid = 1'b0;
        checks++;
        if (prog_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_ack_tied: got %b want 0", prog_ack);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        enter_code(8'hD9);
        tick();
        checks++;
        if (obs !== OPEN0) begin
            errors++;
            $display("[TB] FAIL prog_code_fixed: got %b want %b", obs, OPEN0);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
    endtask
`endif

    task automatic test_reset_in_lockout();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            enter_code(8'h00);
            tick();
            if (n < 2) tick();
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (obs !== LOCKED3) begin
            errors++;
            $display("[TB] FAIL rst_lockout_entered: got %b want %b", obs, LOCKED3);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL rst_lockout_async: got %b want %b", obs, IDLE0);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("[TB] FAIL rst_lockout_after: got %b want %b", obs, IDLE0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        key_valid  = 1'b0;
        key_code   = 8'h00;
        relock     = 1'b0;
        prog_valid = 1'b0;
        prog_code  = 8'h00;
        #1;
        test_reset();
        test_unlock();
        test_lockout();
        test_fail_recovery();
        test_relock();
        test_prog();
        test_reset_in_lockout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Control sequencer in front of the door-lock datapath. It accepts complete 8-bit keypad codes through a valid/ready handshake and compares each against a stored passcode. It drives the lock, unlock, error and lockout indicators, times the open window, and counts failed attempts, locking the keypad out after too many failures. It sits between the keypad scanner and the door indicator/actuator outputs.

## Interface
- CODE, 8'hD9: passcode loaded at reset.
- MAX_FAIL, 3: consecutive failures that trigger lockout (≥1).
- OPEN_CYCLES, 16: cycles the door stays unlocked (≥1).
- LOCKOUT_CYCLES, 64: cycles the keypad is locked out (≥1).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- key_valid  in  1  key_code holds a complete entry.
- key_code  in  8  entered code.
- key_ready  out  1  sequencer can accept an entry.
- relock  in  1  force early relock while open.
- prog_valid  in  1  passcode write request.
- prog_code  in  8  new passcode.
- prog_ack  out  1  one-cycle pulse: passcode written.
- locked  out  1  door locked.
- unlocked  out  1  door unlocked.
- error  out  1  wrong code, or lockout active.
- lockout  out  1  keypad locked out.
- fail_cnt  out  2  consecutive failures (saturates at MAX_FAIL).

## Operation
- States: IDLE, CHECK, OPEN, FAIL, LOCKOUT. Outputs are Moore-decoded from the registered state, except prog_ack, which is registered.
- Reset values: state IDLE, passcode CODE, fail_cnt 0, timer 0, locked 1, unlocked 0, error 0, lockout 0, prog_ack 0, key_ready 1.
- key_ready = (state==IDLE). An entry is accepted on a clock edge where key_valid && key_ready. key_valid outside IDLE is ignored, not queued.
- IDLE: on acceptance, capture key_code and go to CHECK.
- CHECK: compare the captured key against the passcode.
  - Match: go to OPEN, clear fail_cnt, load timer with OPEN_CYCLES-1.
  - Mismatch with fail_cnt==MAX_FAIL-1: go to LOCKOUT, set fail_cnt=MAX_FAIL, load timer with LOCKOUT_CYCLES-1.
  - Other mismatch: go to FAIL and increment fail_cnt.
- FAIL: error=1 for one cycle, then IDLE.
- OPEN: locked=0, unlocked=1. Timer decrements each cycle. Go to IDLE when timer==0 or relock=1, whichever comes first; both in the same cycle also gives IDLE.
- LOCKOUT: error=1, lockout=1, locked=1. When timer==0, go to IDLE and clear fail_cnt.
- locked = !unlocked in every state.
- Timer width is $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)+1). The timer never wraps; it holds at 0 outside OPEN and LOCKOUT.
- Reset mid-operation: all registers return to reset values immediately, including passcode=CODE and fail_cnt=0.

## Timing
- Entry accepted at edge N: CHECK during cycle N+1; OPEN, FAIL or LOCKOUT indicators visible from cycle N+2.
- OPEN lasts exactly OPEN_CYCLES cycles unless relock ends it; relock seen at edge M gives IDLE at M+1.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- FAIL lasts exactly 1 cycle, so the earliest next acceptance is the edge at the end of cycle N+3.
- prog_ack rises in the cycle after the accepting edge and stays high for one cycle.

## Configuration
- LOCK_PROG_EN defined:
  - prog_valid sampled in OPEN loads prog_code into the passcode at that edge and pulses prog_ack.
  - The new passcode applies from the next attempt.
  - prog_valid outside OPEN is ignored.
  - prog_valid and relock in the same cycle: the write is accepted and relock also proceeds.
- LOCK_PROG_EN undefined: the passcode is the constant CODE. prog_valid and prog_code are ignored and prog_ack is tied 0.

## Test plan
- Reset, then key_code=8'hD9 with key_valid → unlocked=1 from cycle N+2 for exactly 16 cycles, then locked=1 and key_ready=1.
- Three entries of 8'h00 → error pulses with fail_cnt 1, then 2; third entry gives lockout=1 for 64 cycles; then fail_cnt=0 and 8'hD9 unlocks.
- Two wrong entries, then 8'hD9 → unlocks and fail_cnt=0; a later single wrong entry gives fail_cnt=1, not lockout.
- While OPEN, assert key_valid (ignored, key_ready=0) and relock at cycle 5 of OPEN → IDLE the next cycle; key_valid during LOCKOUT is likewise ignored.
- LOCK_PROG_EN: in OPEN, prog_code=8'h3C → prog_ack pulse. Next, 8'hD9 fails and 8'h3C unlocks. Asserting rst restores 8'hD9.
- Assert rst during LOCKOUT with fail_cnt=3 → immediately lockout=0, error=0, fail_cnt=0, key_ready=1.
